// File: rtl/ip_planar_sched_pkg.sv
// Shared types and helpers for the planar intra predictor block scheduler.
package ip_planar_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    localparam int          SIZE_FIELD_LSB = 0;
    localparam int          SIZE_FIELD_W   = 3;
    localparam logic [2:0]  SIZE_MIN       = 3'd2;
    localparam logic [2:0]  SIZE_MAX       = 3'd5;
    localparam int          BEAT_W         = 9;

    // N*N/4 output beats for a block of size N = 1 << clamp(s, 2, 5)
    function automatic logic [BEAT_W-1:0] planar_beats(input logic [SIZE_FIELD_W-1:0] s);
        logic [SIZE_FIELD_W-1:0] sc;
        logic [3:0]              shamt;
        if (s < SIZE_MIN) begin
            sc = SIZE_MIN;
        end else if (s > SIZE_MAX) begin
            sc = SIZE_MAX;
        end else begin
            sc = s;
        end
        shamt = {sc, 1'b0} - 4'd2;
        planar_beats = 9'd1 << shamt;
    endfunction

endpackage

// File: rtl/ip_planar_sched_if.sv
// Handshake and memory-port bundle between the scheduler and its environment.
interface ip_planar_sched_if #(
    parameter int CONF_W = 20,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic [CONF_W-1:0] req_conf_dat;
    logic              req_vld;
    logic              req_rdy;
    logic [DATA_W-1:0] ref_dat;
    logic              ref_last;
    logic              ref_vld;
    logic              ref_rdy;
    logic              wren;
    logic [ADDR_W-1:0] wraddress;
    logic [DATA_W-1:0] wdata;
    logic [CONF_W-1:0] conf_out_dat;
    logic              conf_out_vld;
    logic              conf_out_rdy;
    logic              pred_mon_vld;
    logic              pred_mon_rdy;
    logic              busy;
    logic              done;
    logic              err_ovf;

    modport slave (
        input  req_conf_dat, req_vld, ref_dat, ref_last, ref_vld,
               conf_out_rdy, pred_mon_vld, pred_mon_rdy,
        output req_rdy, ref_rdy, wren, wraddress, wdata,
               conf_out_dat, conf_out_vld, busy, done, err_ovf
    );

    modport master (
        output req_conf_dat, req_vld, ref_dat, ref_last, ref_vld,
               conf_out_rdy, pred_mon_vld, pred_mon_rdy,
        input  req_rdy, ref_rdy, wren, wraddress, wdata,
               conf_out_dat, conf_out_vld, busy, done, err_ovf
    );
endinterface

// File: rtl/ip_planar_ref_loader.sv
// Reference word writer: address counter, registered memory write port and overflow flag.
module ip_planar_ref_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              clr,
    input  logic              en,
    input  logic              ref_vld,
    input  logic              ref_last,
    input  logic [DATA_W-1:0] ref_dat,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] wdata,
    output logic              err_ovf,
    output logic              last_acc
);
    localparam int CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] addr;
    logic             acc;
    logic             full;

    assign acc      = en & ref_vld;
    assign full     = addr[ADDR_W];
    assign last_acc = acc & ref_last;

    // Once the top address is used the counter parks at full; extra words only raise err_ovf
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            addr      <= '0;
            wren      <= 1'b0;
            wraddress <= '0;
            wdata     <= '0;
            err_ovf   <= 1'b0;
        end else if (clr) begin
            addr    <= '0;
            wren    <= 1'b0;
            err_ovf <= 1'b0;
        end else if (acc) begin
            if (full) begin
                wren    <= 1'b0;
                err_ovf <= 1'b1;
            end else begin
                wren      <= 1'b1;
                wraddress <= addr[ADDR_W-1:0];
                wdata     <= ref_dat;
                addr      <= addr + CNT_W'(1);
            end
        end else begin
            wren <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_planar_sched.sv
// Planar predictor block scheduler: loads reference memory, issues the conf word,
// then counts predictor output beats until the block is complete.
module ip_planar_sched
    import ip_planar_pkg::*;
#(
    parameter int CONF_W   = 20,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int SIZE_LSB = SIZE_FIELD_LSB
) (
    input  logic            clk,
    input  logic            arst,
    ip_planar_sched_if.slave bus
);
    state_t              state;
    logic [CONF_W-1:0]   conf_q;
    logic [BEAT_W-1:0]   beats;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                done_q;
    logic                req_acc;
    logic                last_acc;
    logic                beat;

    // req_rdy is held low for as long as reset is asserted
    assign bus.req_rdy      = (state == IDLE) & ~arst;
    assign bus.ref_rdy      = (state == LOAD);
    assign bus.conf_out_vld = (state == ISSUE);
    assign bus.conf_out_dat = conf_q;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;

    assign req_acc = bus.req_vld & bus.req_rdy;
    assign beat    = bus.pred_mon_vld & bus.pred_mon_rdy;

    ip_planar_ref_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk       (clk),
        .arst      (arst),
        .clr       (req_acc),
        .en        (state == LOAD),
        .ref_vld   (bus.ref_vld),
        .ref_last  (bus.ref_last),
        .ref_dat   (bus.ref_dat),
        .wren      (bus.wren),
        .wraddress (bus.wraddress),
        .wdata     (bus.wdata),
        .err_ovf   (bus.err_ovf),
        .last_acc  (last_acc)
    );

    // Block sequencing FSM; predictor beats are only counted while in WAIT
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            conf_q   <= '0;
            beats    <= '0;
            beat_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_acc) begin
                        conf_q <= bus.req_conf_dat;
                        beats  <= planar_beats(bus.req_conf_dat[SIZE_LSB +: SIZE_FIELD_W]);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (last_acc) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (bus.conf_out_rdy) begin
                        beat_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (beat) begin
                        if (beat_cnt == beats - 9'd1) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_planar_sched.sv
// Scoreboard bench for ip_planar_sched: expected memory writes are queued as words are driven
// and popped when the write strobe appears; block timing and flags are checked per scenario.
module tb_ip_planar_sched;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   cyc  = 0;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    logic [37:0] exp_wr[$];
    logic [37:0] wr_exp_v;

    int   r_lat;
    int   r_conf_bad;
    int   r_done_bad;
    int   r_prot_bad;
    logic r_ovf_acc;
    logic r_ovf_end;
    logic r_acc_done;

    ip_planar_sched_if #(.CONF_W(20), .DATA_W(32), .ADDR_W(6)) bus ();

    ip_planar_sched dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    wire [64:0] outs = {bus.req_rdy, bus.ref_rdy, bus.wren, bus.wraddress, bus.wdata,
                        bus.conf_out_dat, bus.conf_out_vld, bus.busy, bus.done, bus.err_ovf};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wren === 1'b1) begin
                wr_seen++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr=%0d data=%h, expected no write", bus.wraddress, bus.wdata);
                end else begin
                    wr_exp_v = exp_wr.pop_front();
                    if ({bus.wraddress, bus.wdata} !== wr_exp_v) begin
                        errors++;
                        $display("FAIL wr_word: addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus.wraddress, bus.wdata, wr_exp_v[37:32], wr_exp_v[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Drives one full block and records what it observed; the caller compares
    task automatic run_block(input logic [19:0] conf, input int nwords, input logic [31:0] base,
                             input int stall, input int exp_beats, input bit hold_ref,
                             input bit issue_beats, input int abort_after);
        int guard;
        int acc;
        int sent;
        bit hs;
        bit pv;
        bit pr;
        r_conf_bad = 0; r_done_bad = 0; r_prot_bad = 0; r_lat = -1;
        bus.req_conf_dat = conf;
        bus.req_vld = 1'b1;
        guard = 0;
        while (bus.req_rdy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin
            checks++; errors++; bus.req_vld = 1'b0;
            $display("FAIL req_timeout: req_rdy never seen, expected within 50 cycles");
            return;
        end
        r_acc_done = bus.done;
        acc = cyc;
        @(negedge clk);
        bus.req_vld = 1'b0;
        r_ovf_acc = bus.err_ovf;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) r_done_bad++;
        for (int i = 0; i < nwords; i++) begin
            bus.ref_vld  = 1'b1;
            bus.ref_dat  = base + 32'(i);
            bus.ref_last = (i == nwords - 1);
            guard = 0;
            while (bus.ref_rdy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) begin
                checks++; errors++; bus.ref_vld = 1'b0; bus.ref_last = 1'b0;
                $display("FAIL ref_timeout: word %0d not accepted, expected within 50 cycles", i);
                return;
            end
            if (i < 64) exp_wr.push_back({6'(i), base + 32'(i)});
            @(negedge clk);
        end
        bus.ref_last = 1'b0;
        bus.ref_vld  = hold_ref;
        bus.ref_dat  = 32'hDEAD_BEEF;
        guard = 0;
        while (bus.conf_out_vld !== 1'b1 && guard < 50) begin
            if (hold_ref && bus.ref_rdy !== 1'b0) r_prot_bad++;
            @(negedge clk); guard++;
        end
        if (guard >= 50) begin
            checks++; errors++; bus.ref_vld = 1'b0;
            $display("FAIL conf_vld_timeout: conf_out_vld never rose, expected within 50 cycles");
            return;
        end
        r_lat = cyc - acc;
        guard = 0;
        do begin
            if (bus.conf_out_vld !== 1'b1 || bus.conf_out_dat !== conf) r_conf_bad++;
            if (hold_ref && bus.ref_rdy !== 1'b0) r_prot_bad++;
            bus.pred_mon_vld = issue_beats;
            bus.pred_mon_rdy = issue_beats;
            hs = (issue_beats && guard < 3) ? 1'b0 : ($urandom_range(99, 0) >= stall);
            bus.conf_out_rdy = hs;
            @(negedge clk); guard++;
        end while (!hs && guard < 200);
        bus.conf_out_rdy = 1'b0;
        bus.pred_mon_vld = 1'b0;
        bus.pred_mon_rdy = 1'b0;
        sent = 0; guard = 0;
        while (sent < exp_beats && sent != abort_after && guard < 5000) begin
            if (hold_ref && bus.ref_rdy !== 1'b0) r_prot_bad++;
            pv = ($urandom_range(99, 0) >= stall);
            pr = ($urandom_range(99, 0) >= stall);
            bus.pred_mon_vld = pv;
            bus.pred_mon_rdy = pr;
            if (pv && pr) sent++;
            @(negedge clk); guard++;
            if (bus.done !== ((sent == exp_beats) ? 1'b1 : 1'b0)) r_done_bad++;
        end
        bus.pred_mon_vld = 1'b0;
        bus.pred_mon_rdy = 1'b0;
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL beat_timeout: %0d beats sent, expected %0d", sent, exp_beats);
        end
        r_ovf_end = bus.err_ovf;
        if (hold_ref && bus.ref_rdy !== 1'b0) r_prot_bad++;
        bus.ref_vld = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_conf_dat = '0; bus.req_vld = 1'b0; bus.ref_dat = '0; bus.ref_last = 1'b0;
        bus.ref_vld = 1'b0; bus.conf_out_rdy = 1'b0; bus.pred_mon_vld = 1'b0; bus.pred_mon_rdy = 1'b0;
        arst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== 65'd0) begin errors++; $display("FAIL reset_outputs: got %h, expected 0", outs); end
        arst = 1'b0;
        #1;
        checks++;
        if (bus.req_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: req_rdy=%b busy=%b, expected 1 0", bus.req_rdy, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_small_block();
        int w0;
        w0 = wr_seen;
        run_block(20'h00002, 3, 32'h1000_0000, 0, 4, 1'b0, 1'b0, -1);
        checks++;
        if (r_lat !== 5) begin errors++; $display("FAIL small_latency: got %0d, expected 5", r_lat); end
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL small_done: %0d bad cycles, expected 0", r_done_bad); end
        checks++;
        if (r_conf_bad !== 0) begin errors++; $display("FAIL small_conf: %0d bad cycles, expected 0", r_conf_bad); end
        checks++;
        if (wr_seen - w0 !== 3 || exp_wr.size() !== 0) begin
            errors++; $display("FAIL small_writes: got %0d strobes, expected 3", wr_seen - w0);
        end
    endtask

    task automatic test_big_stalled();
        run_block(20'h5A3C5, 8, 32'h2000_0100, 40, 256, 1'b0, 1'b0, -1);
        checks++;
        if (r_lat !== 10) begin errors++; $display("FAIL big_latency: got %0d, expected 10", r_lat); end
        checks++;
        if (r_conf_bad !== 0) begin errors++; $display("FAIL big_conf_stable: %0d bad cycles, expected 0", r_conf_bad); end
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL big_done_256: %0d bad cycles, expected 0", r_done_bad); end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = wr_seen;
        run_block(20'h00002, 70, 32'h3000_0000, 0, 4, 1'b0, 1'b0, -1);
        checks++;
        if (wr_seen - w0 !== 64 || exp_wr.size() !== 0) begin
            errors++; $display("FAIL ovf_writes: got %0d strobes, expected 64", wr_seen - w0);
        end
        checks++;
        if (r_ovf_end !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", r_ovf_end); end
        w0 = wr_seen;
        run_block(20'h00003, 64, 32'h4000_0000, 0, 16, 1'b0, 1'b0, -1);
        checks++;
        if (r_ovf_acc !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", r_ovf_acc); end
        checks++;
        if (r_ovf_end !== 1'b0 || wr_seen - w0 !== 64) begin
            errors++; $display("FAIL full64: err_ovf=%b strobes=%0d, expected 0 64", r_ovf_end, wr_seen - w0);
        end
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL full64_done: %0d bad cycles, expected 0", r_done_bad); end
    endtask

    task automatic test_size_clamp();
        run_block(20'h00007, 2, 32'h5000_0000, 0, 256, 1'b0, 1'b0, -1);
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL clamp_code7: %0d bad cycles, expected 0", r_done_bad); end
        run_block(20'hFFFF8, 2, 32'h5100_0000, 0, 4, 1'b0, 1'b0, -1);
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL clamp_code0: %0d bad cycles, expected 0", r_done_bad); end
        checks++;
        if (r_conf_bad !== 0) begin errors++; $display("FAIL clamp_conf: %0d bad cycles, expected 0", r_conf_bad); end
    endtask

    task automatic test_protect();
        run_block(20'h00003, 4, 32'h6000_0000, 0, 16, 1'b1, 1'b1, -1);
        checks++;
        if (r_prot_bad !== 0) begin errors++; $display("FAIL protect_ref_rdy: %0d bad cycles, expected 0", r_prot_bad); end
        checks++;
        if (r_done_bad !== 0) begin errors++; $display("FAIL protect_issue_beats: %0d bad cycles, expected 0", r_done_bad); end
        checks++;
        if (exp_wr.size() !== 0) begin errors++; $display("FAIL protect_writes: %0d pending, expected 0", exp_wr.size()); end
    endtask

    task automatic test_arst_abort();
        int bad;
        run_block(20'h00004, 5, 32'h7000_0000, 0, 64, 1'b0, 1'b0, 10);
        arst = 1'b1;
        #1;
        checks++;
        if (outs !== 65'd0) begin errors++; $display("FAIL arst_outputs: got %h, expected 0", outs); end
        @(negedge clk);
        checks++;
        if (outs !== 65'd0) begin errors++; $display("FAIL arst_hold: got %h, expected 0", outs); end
        arst = 1'b0;
        #1;
        checks++;
        if (bus.req_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL arst_idle: req_rdy=%b busy=%b, expected 1 0", bus.req_rdy, bus.busy);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL arst_no_done: %0d done cycles, expected 0", bad); end
        run_block(20'h00004, 2, 32'h7100_0000, 0, 64, 1'b0, 1'b0, -1);
        checks++;
        if (r_done_bad !== 0 || r_lat !== 4) begin
            errors++; $display("FAIL arst_recover: bad=%0d lat=%0d, expected 0 4", r_done_bad, r_lat);
        end
    endtask

    task automatic test_back_to_back();
        run_block(20'h00002, 1, 32'h8000_0000, 0, 4, 1'b0, 1'b0, -1);
        run_block(20'h00003, 2, 32'h8100_0000, 0, 16, 1'b0, 1'b0, -1);
        checks++;
        if (r_acc_done !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_done: done=%b at accept, expected 1", r_acc_done); end
        checks++;
        if (r_lat !== 4 || r_done_bad !== 0) begin
            errors++; $display("FAIL b2b_block: lat=%0d bad=%0d, expected 4 0", r_lat, r_done_bad);
        end
    endtask

    initial begin
        test_reset();
        test_small_block();
        test_big_stalled();
        test_overflow();
        test_size_clamp();
        test_protect();
        test_arst_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_wr.size() !== 0) begin errors++; $display("FAIL wr_leftover: %0d pending, expected 0", exp_wr.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
